// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: loadable register, async reset to the boot address.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= pc_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem request, one-entry holding register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            ifid_we,
    output logic            ifid_empty,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic [31:0]     if_instr
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_pc_q;
    logic [31:0]     hold_instr_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic            pc_load, accept, capture, hold_busy;

    assign ifid_we    = !stall_i || redirect_i;
    assign ifid_empty = redirect_i || !hold_valid_q;

    // Only issue when the holding register is free by the end of this cycle, so a
    // response can always be captured without overwriting an unconsumed instruction.
    assign hold_busy      = hold_valid_q && !ifid_we;
    assign imem_req_valid = (state_q == StReq) && !hold_busy;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign capture        = (state_q == StWait) && imem_rsp_valid && !kill_q && !redirect_i;

    assign pc_load       = redirect_i || accept;
    assign fetch_pc_next = redirect_i ? (redirect_pc_i & ~XLEN'(3)) : fetch_pc + XLEN'(4);

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .pc_i   (fetch_pc_next),
        .pc_o   (fetch_pc)
    );

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        if (redirect_i) begin
            hold_valid_d = 1'b0;
        end else if (capture) begin
            hold_valid_d = 1'b1;
        end else if (ifid_we) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (accept) begin
                    state_d = StWait;
                    kill_d  = redirect_i;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    kill_d  = 1'b0;
                    state_d = (capture && stall_i) ? StHold : StReq;
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                if (ifid_we) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            kill_q        <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_pc_q     <= RESET_PC;
            hold_instr_q  <= NOP_INSTR;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            hold_valid_q <= hold_valid_d;
            if (accept) begin
                inflight_pc_q <= fetch_pc;
            end
            if (capture) begin
                hold_pc_q    <= inflight_pc_q;
                hold_instr_q <= imem_rsp_data;
            end
        end
    end

    assign if_pc    = hold_pc_q;
    assign if_pc4   = hold_pc_q + XLEN'(4);
    assign if_instr = hold_instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (ifid_we && !ifid_empty) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (stall_i && hold_valid_q) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, cycle-exact bench for fetch_stage with a behavioural variable-latency imem.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = 32'd0;
    logic        stall     = 1'b0;
    logic        redirect  = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ifid_we, ifid_empty;
    logic [31:0] if_pc, if_pc4, if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .stall_i        (stall),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .ifid_we        (ifid_we),
        .ifid_empty     (ifid_empty),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    // Memory model: instruction at address a is ~a; latency in cycles after acceptance.
    int unsigned lat = 1;
    int unsigned cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    always @(posedge clk) begin
        rsp_valid <= 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ~pend_addr;
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (req_valid && req_ready) begin
            if (lat <= 1) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ~req_addr;
                pend      <= 1'b0;
            end else begin
                pend      <= 1'b1;
                pend_addr <= req_addr;
                cnt       <= lat - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        mid();
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_empty", 32'(ifid_empty), 32'd1);

        cyc(); rst = 1'b0; mid();                       // C0 idle
        check("c0_idle_valid", 32'(req_valid), 32'd0);
        cyc(); mid();                                   // C1
        check("c1_valid", 32'(req_valid), 32'd1);
        check("c1_addr", req_addr, 32'h0);
        cyc(); mid();                                   // C2 wait
        check("c2_valid", 32'(req_valid), 32'd0);
        check("c2_empty", 32'(ifid_empty), 32'd1);
        cyc(); mid();                                   // C3 deliver 0
        check("c3_addr", req_addr, 32'h4);
        check("c3_if_pc", if_pc, 32'h0);
        check("c3_if_pc4", if_pc4, 32'h4);
        check("c3_instr", if_instr, 32'hFFFF_FFFF);
        check("c3_empty", 32'(ifid_empty), 32'd0);
        cyc(); mid();
        cyc(); mid();                                   // C5 deliver 4
        check("c5_if_pc", if_pc, 32'h4);
        check("c5_instr", if_instr, 32'hFFFF_FFFB);
        check("c5_addr", req_addr, 32'h8);
        cyc(); mid();
        cyc(); mid();                                   // C7 deliver 8
        check("c7_if_pc", if_pc, 32'h8);
        check("c7_empty", 32'(ifid_empty), 32'd0);
        check("c7_addr", req_addr, 32'hC);

        // Stall arrives with the response for 0xC -> HOLD
        cyc(); stall = 1'b1; mid();                     // C8
        check("c8_we", 32'(ifid_we), 32'd0);
        for (int i = 0; i < 5; i++) begin               // C9..C13
            cyc(); mid();
            check("stall_we", 32'(ifid_we), 32'd0);
            check("stall_if_pc", if_pc, 32'hC);
            check("stall_valid", 32'(req_valid), 32'd0);
            check("stall_empty", 32'(ifid_empty), 32'd0);
        end
        cyc(); stall = 1'b0; mid();                     // C14 consume 0xC
        check("c14_we", 32'(ifid_we), 32'd1);
        check("c14_if_pc", if_pc, 32'hC);
        check("c14_valid", 32'(req_valid), 32'd0);
        cyc(); lat = 3; mid();                          // C15
        check("c15_valid", 32'(req_valid), 32'd1);
        check("c15_addr", req_addr, 32'h10);

        // Redirect while waiting on a 3-cycle response
        cyc(); redirect = 1'b1; redirect_pc = 32'h103; mid();   // C16
        check("redir_we", 32'(ifid_we), 32'd1);
        check("redir_empty", 32'(ifid_empty), 32'd1);
        cyc(); redirect = 1'b0; mid();                  // C17
        check("c17_valid", 32'(req_valid), 32'd0);
        cyc(); mid();                                   // C18 stale response
        check("stale_empty", 32'(ifid_empty), 32'd1);
        check("stale_valid", 32'(req_valid), 32'd0);
        cyc(); lat = 1; mid();                          // C19
        check("redir_valid", 32'(req_valid), 32'd1);
        check("redir_addr", req_addr, 32'h100);
        check("redir_no_capture", 32'(ifid_empty), 32'd1);
        cyc(); mid();
        cyc(); mid();                                   // C21 deliver 0x100
        check("c21_if_pc", if_pc, 32'h100);
        check("c21_instr", if_instr, 32'hFFFF_FEFF);
        check("c21_addr", req_addr, 32'h104);
        check("c21_empty", 32'(ifid_empty), 32'd0);

        // Redirect together with stall, accepted in the same cycle
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("rs_we", 32'(ifid_we), 32'd1);
        check("rs_empty", 32'(ifid_empty), 32'd1);
        cyc(); stall = 1'b0; redirect = 1'b0; mid();    // C22 killed response
        check("c22_valid", 32'(req_valid), 32'd0);
        check("c22_empty", 32'(ifid_empty), 32'd1);
        cyc(); mid();                                   // C23
        check("c23_addr", req_addr, 32'hFFFF_FFFC);
        check("c23_valid", 32'(req_valid), 32'd1);
        cyc(); mid();
        cyc(); lat = 3; mid();                          // C25 wrap
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_pc4", if_pc4, 32'h0);
        check("wrap_instr", if_instr, 32'h3);
        check("wrap_addr", req_addr, 32'h0);

        // Reset with a request outstanding; the late response must be ignored
        cyc(); rst = 1'b1; req_ready = 1'b0; mid();     // C26
        check("mid_rst_valid", 32'(req_valid), 32'd0);
        check("mid_rst_instr", if_instr, 32'h0000_0013);
        check("mid_rst_addr", req_addr, 32'h0);
        cyc(); rst = 1'b0; mid();                       // C27 idle
        check("c27_valid", 32'(req_valid), 32'd0);
        cyc(); mid();                                   // C28 late response
        check("late_empty", 32'(ifid_empty), 32'd1);
        check("late_valid", 32'(req_valid), 32'd1);
        cyc(); req_ready = 1'b1; lat = 1; mid();        // C29
        check("late_ignored", 32'(ifid_empty), 32'd1);
        check("late_pc", if_pc, 32'h0);
        cyc(); mid();
        cyc(); mid();                                   // C31
        check("post_rst_instr", if_instr, 32'hFFFF_FFFF);
        check("post_rst_empty", 32'(ifid_empty), 32'd0);

`ifdef FETCH_PERF_EN
        cyc(); rst = 1'b1; mid();
        check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
        cyc(); rst = 1'b0;                              // C0
        for (int i = 0; i < 22; i++) cyc();             // C22
        stall = 1'b1;
        mid();
        check("perf_fetch10", perf_fetch_cnt, 32'd10);
        for (int i = 0; i < 3; i++) begin
            cyc(); mid();
        end
        cyc(); stall = 1'b0; mid();                     // C26
        check("perf_stall3", perf_stall_cnt, 32'd3);
        check("perf_fetch_hold", perf_fetch_cnt, 32'd10);
        cyc(); mid();
        check("perf_fetch11", perf_fetch_cnt, 32'd11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock; reset rst, asynchronous, active-high.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  XLEN  fetch address, bits[1:0] always 0.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction returned this cycle.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction.
REQ-010 SHALL have port stall_i  input  1  hazard stall; IF/ID must hold.
REQ-011 SHALL have port redirect_i / redirect_pc_i  input  1 / XLEN  taken branch/jump from EX and its target.
REQ-012 SHALL have port ifid_we / ifid_empty  output  1 / 1  write-enable and bubble-insert for the IF/ID register.
REQ-013 SHALL have port if_pc / if_pc4 / if_instr  output  XLEN / XLEN / 32  data for the IF/ID register.

Function
REQ-014 SHALL allow at most one outstanding memory request; request accepted when imem_req_valid && imem_req_ready.
REQ-015 SHALL implement FSM: IDLE (one cycle after reset) -> REQ; REQ -(accept)-> WAIT; WAIT -(rsp, holding reg consumable or empty)-> REQ; WAIT -(rsp, holding reg stalled)-> HOLD; HOLD -(holding reg consumed)-> REQ.
REQ-016 SHALL capture imem_rsp_data and its PC into a holding register (hold_valid, hold_pc, hold_instr) on response.
REQ-017 SHALL drive if_pc=hold_pc, if_pc4=hold_pc+4 (mod 2^XLEN, wrap silent), if_instr=hold_instr.
REQ-018 SHALL drive ifid_we = !stall_i || redirect_i.
REQ-019 SHALL drive ifid_empty = redirect_i || !hold_valid.
REQ-020 SHALL clear hold_valid in any cycle with ifid_we=1 and no new response being captured.
REQ-021 SHALL advance fetch PC by 4 on each request acceptance.
REQ-022 SHALL keep imem_req_addr stable while imem_req_valid=1 and not accepted, except on redirect.
REQ-023 On redirect_i: SHALL load fetch PC with {redirect_pc_i[XLEN-1:2],2'b00} and clear hold_valid; redirect wins over stall_i.
REQ-024 Redirect in REQ: next request SHALL use the new PC, even if the old one was accepted in the same cycle.
REQ-025 Redirect in WAIT (or accepted in the same cycle): SHALL set a kill flag, discard the next response, clear kill, then go to REQ.
REQ-026 Simultaneous redirect_i and imem_rsp_valid: response SHALL be dropped.

Reset
REQ-027 On rst: state=IDLE, fetch PC=RESET_PC, hold_valid=0, kill=0, imem_req_valid=0, imem_req_addr=RESET_PC, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP).
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; a late response after reset deassertion SHALL be ignored until the first new request is accepted.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: SHALL add outputs perf_fetch_cnt (32, instructions consumed with ifid_empty=0) and perf_stall_cnt (32, cycles with stall_i=1 and hold_valid=1); both reset to 0, wrap at 2^32.
REQ-030 Macro FETCH_PERF_EN undefined: SHALL have neither those ports nor those counters.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, NOP_INSTR constant and default RESET_PC.
REQ-032 Sub-module pc_reg (XLEN register, async reset to RESET_PC, load enable) SHALL hold the fetch PC.

Verification
REQ-033 Reset, ready=1, 1-cycle latency, no stall -> addresses 0x0,0x4,0x8; if_instr order matches; ifid_empty=0 on delivery cycles.
REQ-034 stall_i=1 for 5 cycles with hold_valid=1 -> ifid_we=0, if_pc constant, imem_req_valid=0 after HOLD entry.
REQ-035 redirect_i with redirect_pc_i=0x103 while in WAIT -> stale response dropped, ifid_empty=1, next imem_req_addr=0x100.
REQ-036 redirect_i and stall_i together -> ifid_we=1, ifid_empty=1.
REQ-037 Fetch PC 0xFFFF_FFFC -> if_pc4=0x0, next request address 0x0.
REQ-038 FETCH_PERF_EN defined, 10 delivered instructions, 3 stalled cycles -> perf_fetch_cnt=10, perf_stall_cnt=3.
